life_gen_ctrl: RTL and testbench
================================

// Module: life_gen_ctrl
// PURPOSE
//  Sequencer for the Game-of-Life cell-register bank (one SIZE=COLS register per row).
//  Drives per-row write enables to load an initial pattern row by row. Then issues a
//  global "latch next state" enable once per generation: single step, N generations,
//  or free-run. Sits between host/control logic and the grid of write-enabled registers.
// PARAMETERS
//  ROWS   8   number of grid rows (>=2)
//  COLS   8   cells per row; width of load data
//  GEN_W  16  width of generation limit and counter
// PORTS
//  clk           in   1          rising-edge clock
//  reset         in   1          synchronous, active-high reset
//  load_valid    in   1          host offers load_row
//  load_ready    out  1          ctrl accepts a row; = (state==IDLE) & !start
//  load_row      in   COLS       row pattern to write
//  start         in   1          begin RUN; clears gen_count
//  step          in   1          single generation while IDLE
//  stop          in   1          abort RUN, or leave DONE
//  gen_limit     in   GEN_W      generations per run; 0 = unlimited; sampled at start
//  row_we        out  ROWS       one-hot row write enable to grid registers
//  row_data      out  COLS       registered copy of accepted load_row
//  gen_we        out  1          one-cycle pulse: all cells latch next state
//  busy          out  1          state==RUN
//  done          out  1          state==DONE
//  gen_count     out  GEN_W      generations issued since last start/reset (saturating)
// BEHAVIOUR
//  - Reset: state IDLE, row_ptr 0, gen_count 0, limit reg 0.
//    row_we, row_data, gen_we, busy, done all 0. All outputs registered except load_ready.
//  - States: IDLE, RUN, DONE.
//  - Load (IDLE): load_valid&load_ready -> next cycle row_we[row_ptr]=1, row_data=load_row.
//    row_ptr+1, wraps ROWS-1 -> 0. One row per cycle max. Latency 1.
//  - step in IDLE (no start): gen_we=1 next cycle, gen_count+1, stay IDLE.
//    Same-cycle load handshake and step: both happen.
//  - start in IDLE or DONE: gen_count<=0, latch gen_limit, row_ptr<=0, go RUN.
//    start has priority over step and load.
//  - RUN: one gen_we pulse per period (see CONFIGURATION), gen_count+1 per pulse.
//    When a pulse makes gen_count==limit (limit!=0): next state DONE, no further pulses.
//  - stop in RUN: IDLE next edge; no gen_we issued that cycle; gen_count held.
//    stop beats a coincident limit hit.
//  - DONE: done=1, gen_we=0. start -> RUN; stop -> IDLE. step and load ignored.
//  - gen_count saturates at 2^GEN_W-1 and never wraps. Pulses continue in unlimited mode.
//  - reset at any time, including mid-RUN or mid-load, overrides all inputs.
//    Grid contents are not touched.
// CONFIGURATION
//  LIFE_GEN_PERIOD_EN defined: adds input step_period[GEN_W-1:0], sampled at start.
//    RUN issues gen_we every step_period+1 cycles; first pulse on the 1st RUN cycle.
//    Internal down-counter resets to the period after each pulse.
//  Not defined: no step_period port. RUN issues gen_we every cycle, first on the 1st RUN cycle.
// TESTING
//  1 reset; load 8 rows 0x01..0x80, load_valid held -> row_we one-hot 0x01..0x80 on
//    consecutive cycles, row_data matches; 9th row writes row 0 (wrap).
//  2 gen_limit=3, start -> gen_we high exactly 3 consecutive cycles; gen_count=3;
//    done=1, busy=0; no more gen_we.
//  3 gen_limit=0, start, stop after 5 RUN cycles -> 5 pulses, gen_count=5, IDLE,
//    load_ready=1.
//  4 IDLE, step x2 -> two gen_we pulses, gen_count=2. start+step same cycle ->
//    gen_count=0, RUN, no extra pulse.
//  5 reset asserted mid-RUN (gen_count=7) -> next cycle all outputs 0, gen_count=0,
//    IDLE; load_ready=1 and a new load goes to row 0.
//  6 LIFE_GEN_PERIOD_EN, step_period=2, gen_limit=2 -> gen_we on RUN cycles 1 and 4;
//    DONE after 2nd pulse.

Source files
------------

// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: sequencer for a Game-of-Life cell-register bank.
// Loads an initial pattern row by row through a valid/ready handshake, then
// issues a global "latch next state" pulse once per generation: single step,
// a limited run of N generations, or free-run.
// Optional feature macro: LIFE_GEN_PERIOD_EN adds a step_period input that
// spaces RUN pulses step_period+1 cycles apart.
module life_gen_ctrl #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [COLS-1:0]  load_row,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic [GEN_W-1:0] gen_limit,
`ifdef LIFE_GEN_PERIOD_EN
  input  logic [GEN_W-1:0] step_period,
`endif
  output logic [ROWS-1:0]  row_we,
  output logic [COLS-1:0]  row_data,
  output logic             gen_we,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count
);

  localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ROWS - 1);
  localparam logic [ROWS-1:0]  ROW_ONE  = ROWS'(1);
  localparam logic [GEN_W-1:0] CNT_MAX  = {GEN_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] row_ptr;
  logic [GEN_W-1:0] limit_reg;
  logic [GEN_W-1:0] count_inc;
  logic             run_pulse;

`ifdef LIFE_GEN_PERIOD_EN
  logic [GEN_W-1:0] period_reg;
  logic [GEN_W-1:0] period_cnt;
`endif

  // Host may hand over a row only while idle and not in the middle of launching a run.
  assign load_ready = (state == IDLE) && !start;

  // Saturating increment of the generation counter.
  assign count_inc = (gen_count == CNT_MAX) ? gen_count : gen_count + 1'b1;

  // Whether the current RUN cycle is a pulse cycle.
`ifdef LIFE_GEN_PERIOD_EN
  assign run_pulse = (period_cnt == '0);
`else
  assign run_pulse = 1'b1;
`endif

  // Sequencer: state, row pointer, generation bookkeeping and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row_ptr   <= '0;
      limit_reg <= '0;
      gen_count <= '0;
      row_we    <= '0;
      row_data  <= '0;
      gen_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef LIFE_GEN_PERIOD_EN
      period_reg <= '0;
      period_cnt <= '0;
`endif
    end else begin
      // Write enables are single-cycle strobes unless re-asserted below.
      row_we <= '0;
      gen_we <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            gen_count <= '0;
            limit_reg <= gen_limit;
            row_ptr   <= '0;
`ifdef LIFE_GEN_PERIOD_EN
            period_reg <= step_period;
            period_cnt <= '0;
`endif
          end else begin
            if (load_valid) begin
              row_we   <= ROW_ONE << row_ptr;
              row_data <= load_row;
              row_ptr  <= (row_ptr == PTR_LAST) ? '0 : row_ptr + 1'b1;
            end
            if (step) begin
              gen_we    <= 1'b1;
              gen_count <= count_inc;
            end
          end
        end

        RUN: begin
          if (stop) begin
            // Abort wins over a pulse and over a coincident limit hit.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (run_pulse) begin
            gen_we    <= 1'b1;
            gen_count <= count_inc;
`ifdef LIFE_GEN_PERIOD_EN
            period_cnt <= period_reg;
`endif
            if ((limit_reg != '0) && (count_inc == limit_reg)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
`ifdef LIFE_GEN_PERIOD_EN
            period_cnt <= period_cnt - 1'b1;
`endif
          end
        end

        DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            gen_count <= '0;
            limit_reg <= gen_limit;
            row_ptr   <= '0;
`ifdef LIFE_GEN_PERIOD_EN
            period_reg <= step_period;
            period_cnt <= '0;
`endif
          end else if (stop) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Testbench for life_gen_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a generation-schedule model of the controller.
module tb_life_gen_ctrl;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int GEN_W = 4;
  localparam int CMAX  = (1 << GEN_W) - 1;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic             clk = 1'b0;
  logic             reset, load_valid, start, step, stop;
  logic             load_ready, gen_we, busy, done;
  logic [COLS-1:0]  load_row, row_data;
  logic [ROWS-1:0]  row_we;
  logic [GEN_W-1:0] gen_limit, gen_count;
`ifdef LIFE_GEN_PERIOD_EN
  logic [GEN_W-1:0] step_period;
`endif

  always #5 clk = ~clk;

  life_gen_ctrl #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_row   (load_row),
    .start      (start),
    .step       (step),
    .stop       (stop),
    .gen_limit  (gen_limit),
`ifdef LIFE_GEN_PERIOD_EN
    .step_period(step_period),
`endif
    .row_we     (row_we),
    .row_data   (row_data),
    .gen_we     (gen_we),
    .busy       (busy),
    .done       (done),
    .gen_count  (gen_count)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int pulses  = 0;

  // Reference model: mode, row pointer, generation count, limit, period and
  // the index of the current cycle within a run.
  bit              m_valid = 0;
  int              m_state, m_ptr, m_count, m_lim, m_per, m_run_idx;
  logic [ROWS-1:0] e_row_we;
  logic [COLS-1:0] e_row_data;
  logic            e_gen_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_launch(input int lim, input int per);
    m_state   = S_RUN;
    m_count   = 0;
    m_lim     = lim;
    m_per     = per;
    m_ptr     = 0;
    m_run_idx = 0;
  endtask

  task automatic do_cycle(input bit rst, input bit lv, input logic [COLS-1:0] row,
                          input bit st, input bit sp, input bit so,
                          input logic [GEN_W-1:0] lim, input logic [GEN_W-1:0] per_in);
    int per_val;
    per_val = int'(per_in);
`ifndef LIFE_GEN_PERIOD_EN
    per_val = 0;
`endif
    reset = rst; load_valid = lv; load_row = row; start = st; step = sp; stop = so;
    gen_limit = lim;
`ifdef LIFE_GEN_PERIOD_EN
    step_period = per_in;
`endif
    #1;
    if (m_valid) check("load_ready", {31'd0, load_ready}, {31'd0, (m_state == S_IDLE) && !st});

    // Advance the model by one clock.
    e_row_we = '0;
    e_gen_we = 1'b0;
    if (rst) begin
      m_valid = 1; m_state = S_IDLE; m_ptr = 0; m_count = 0; m_lim = 0; m_per = 0;
      m_run_idx = 0; e_row_data = '0;
    end else if (m_state == S_IDLE) begin
      if (st) model_launch(int'(lim), per_val);
      else begin
        if (lv) begin
          e_row_we   = '0;
          e_row_we[m_ptr] = 1'b1;
          e_row_data = row;
          m_ptr      = (m_ptr + 1) % ROWS;
        end
        if (sp) begin
          e_gen_we = 1'b1;
          if (m_count < CMAX) m_count++;
        end
      end
    end else if (m_state == S_RUN) begin
      if (so) m_state = S_IDLE;
      else begin
        if (m_run_idx % (m_per + 1) == 0) begin
          e_gen_we = 1'b1;
          if (m_count < CMAX) m_count++;
          if (m_lim != 0 && m_count == m_lim) m_state = S_DONE;
        end
        m_run_idx++;
      end
    end else begin
      if (st) model_launch(int'(lim), per_val);
      else if (so) m_state = S_IDLE;
    end

    @(posedge clk);
    #1;
    cyc++;
    if (gen_we === 1'b1) pulses++;
    $display("cyc %0d rst=%0b lv=%0b st=%0b sp=%0b so=%0b | row_we=%h data=%h gen_we=%0b busy=%0b done=%0b cnt=%0d",
             cyc, rst, lv, st, sp, so, row_we, row_data, gen_we, busy, done, gen_count);
    check("row_we",    32'(row_we),    32'(e_row_we));
    check("row_data",  32'(row_data),  32'(e_row_data));
    check("gen_we",    {31'd0, gen_we}, {31'd0, e_gen_we});
    check("busy",      {31'd0, busy},   {31'd0, m_state == S_RUN});
    check("done",      {31'd0, done},   {31'd0, m_state == S_DONE});
    check("gen_count", 32'(gen_count), 32'(m_count));
  endtask

  task automatic idle_cycle();
    do_cycle(0, 0, '0, 0, 0, 0, '0, '0);
  endtask

  logic [COLS-1:0] pat;

  initial begin
    reset = 1; load_valid = 0; load_row = '0; start = 0; step = 0; stop = 0; gen_limit = '0;
`ifdef LIFE_GEN_PERIOD_EN
    step_period = '0;
`endif
    @(posedge clk); #1;

    // Reset state
    do_cycle(1, 0, '0, 0, 0, 0, '0, '0);
    do_cycle(1, 0, '0, 0, 0, 0, '0, '0);
    check("rst_gen_count", 32'(gen_count), 32'd0);
    check("rst_row_we", 32'(row_we), 32'd0);

    // Load 8 rows 0x01..0x80 back to back, then a 9th that wraps to row 0
    for (int i = 0; i < ROWS; i++) begin
      pat = COLS'(1 << i);
      do_cycle(0, 1, pat, 0, 0, 0, '0, '0);
      check("load_row_we", 32'(row_we), 32'(1 << i));
      check("load_row_data", 32'(row_data), 32'(1 << i));
    end
    do_cycle(0, 1, 8'hAA, 0, 0, 0, '0, '0);
    check("wrap_row_we", 32'(row_we), 32'h01);
    check("wrap_row_data", 32'(row_data), 32'hAA);

    // Limited run of 3 generations
    do_cycle(0, 0, '0, 1, 0, 0, 4'd3, '0);
    pulses = 0;
    for (int i = 0; i < 5; i++) idle_cycle();
    check("lim3_pulses", 32'(pulses), 32'd3);
    check("lim3_count", 32'(gen_count), 32'd3);
    check("lim3_done", {31'd0, done}, 32'd1);
    check("lim3_busy", {31'd0, busy}, 32'd0);
    do_cycle(0, 0, '0, 0, 0, 1, '0, '0);

    // Free run stopped after 5 RUN cycles
    do_cycle(0, 0, '0, 1, 0, 0, 4'd0, '0);
    pulses = 0;
    for (int i = 0; i < 5; i++) idle_cycle();
    do_cycle(0, 0, '0, 0, 0, 1, '0, '0);
    check("stop_pulses", 32'(pulses), 32'd5);
    check("stop_count", 32'(gen_count), 32'd5);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_ready", {31'd0, load_ready}, 32'd1);

    // Two single steps, then start+step together
    pulses = 0;
    do_cycle(0, 0, '0, 0, 1, 0, '0, '0);
    idle_cycle();
    do_cycle(0, 0, '0, 0, 1, 0, '0, '0);
    check("step_pulses", 32'(pulses), 32'd2);
    do_cycle(0, 0, '0, 1, 1, 0, 4'd0, '0);
    check("startstep_count", 32'(gen_count), 32'd0);
    check("startstep_gen_we", {31'd0, gen_we}, 32'd0);
    check("startstep_busy", {31'd0, busy}, 32'd1);

    // Reset in mid-run with gen_count at 7
    for (int i = 0; i < 7; i++) idle_cycle();
    check("midrun_count", 32'(gen_count), 32'd7);
    do_cycle(1, 0, '0, 0, 0, 0, '0, '0);
    check("midrst_count", 32'(gen_count), 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    do_cycle(0, 1, 8'h5A, 0, 0, 0, '0, '0);
    check("midrst_row0", 32'(row_we), 32'h01);

    // Saturation of the generation counter in free run
    do_cycle(0, 0, '0, 1, 0, 0, 4'd0, '0);
    for (int i = 0; i < CMAX + 5; i++) idle_cycle();
    check("sat_count", 32'(gen_count), 32'(CMAX));
    check("sat_gen_we", {31'd0, gen_we}, 32'd1);
    do_cycle(0, 0, '0, 0, 0, 1, '0, '0);

`ifdef LIFE_GEN_PERIOD_EN
    // Period 2, limit 2: pulses on RUN cycles 1 and 4
    do_cycle(0, 0, '0, 1, 0, 0, 4'd2, 4'd2);
    idle_cycle(); check("per_c1", {31'd0, gen_we}, 32'd1);
    idle_cycle(); check("per_c2", {31'd0, gen_we}, 32'd0);
    idle_cycle(); check("per_c3", {31'd0, gen_we}, 32'd0);
    idle_cycle(); check("per_c4", {31'd0, gen_we}, 32'd1);
    check("per_done", {31'd0, done}, 32'd1);
    idle_cycle(); check("per_c5", {31'd0, gen_we}, 32'd0);
    do_cycle(0, 0, '0, 0, 0, 1, '0, '0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      do_cycle(($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 50),
               COLS'($urandom),
               ($urandom_range(0, 99) < 6),
               ($urandom_range(0, 99) < 20),
               ($urandom_range(0, 99) < 6),
               GEN_W'($urandom_range(0, 6)),
               GEN_W'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
